// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: owner of the 64x4 single-port board RAM.
// Shares the RAM between the control FSM, the move validator and the
// datapath, and loads the standard starting position after reset or on
// an init_req pulse.
//
// Handshake: a requester raises x_req with its address (and, for the
// datapath, we/wdata) and holds them stable until x_gnt is high in the
// same cycle; that cycle consumes the access. Reads return one cycle
// later on rdata, qualified by x_rvalid. Writes never return rvalid.
module board_mem_arbiter #(
    parameter int ADDR_W        = 6,
    parameter int DATA_W        = 4,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    output logic              init_busy,
    input  logic              ctl_req,
    input  logic [ADDR_W-1:0] ctl_addr,
    output logic              ctl_gnt,
    output logic              ctl_rvalid,
    input  logic              val_req,
    input  logic [ADDR_W-1:0] val_addr,
    output logic              val_gnt,
    output logic              val_rvalid,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_gnt,
    output logic              dp_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    // rr_last encoding: which of ctl/val was granted most recently
    localparam logic RR_CTL = 1'b0;
    localparam logic RR_VAL = 1'b1;

    localparam state_t RESET_STATE = INIT_ON_RESET ? INIT : IDLE;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_last_q, rr_last_d;
    logic              ctl_rvalid_q, ctl_rvalid_d;
    logic              val_rvalid_q, val_rvalid_d;
    logic              dp_rvalid_q, dp_rvalid_d;

    // Back-rank piece order for column x (black codes; white is +6).
    function automatic logic [DATA_W-1:0] back_rank(input logic [2:0] x);
        logic [DATA_W-1:0] code;
        case (x)
            3'd0, 3'd7: code = DATA_W'(4);   // rook
            3'd1, 3'd6: code = DATA_W'(2);   // knight
            3'd2, 3'd5: code = DATA_W'(3);   // bishop
            3'd3:       code = DATA_W'(5);   // queen
            default:    code = DATA_W'(6);   // king
        endcase
        return code;
    endfunction

    // Starting-position piece code for square a (y = a[5:3], x = a[2:0]).
    function automatic logic [DATA_W-1:0] start_code(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] code;
        case (a[5:3])
            3'd0:    code = back_rank(a[2:0]);
            3'd1:    code = DATA_W'(1);
            3'd6:    code = DATA_W'(7);
            3'd7:    code = back_rank(a[2:0]) + DATA_W'(6);
            default: code = '0;
        endcase
        return code;
    endfunction

    // Next-state, arbitration and RAM port drive.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_last_d    = rr_last_q;
        ctl_gnt      = 1'b0;
        val_gnt      = 1'b0;
        dp_gnt       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        init_busy    = 1'b0;
        ctl_rvalid_d = 1'b0;
        val_rvalid_d = 1'b0;
        dp_rvalid_d  = 1'b0;

        if (reset) begin
            // Nobody touches the RAM while reset is held.
            init_busy = 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    init_busy = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cnt_q;
                    mem_wdata = start_code(cnt_q);
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (&cnt_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    if (dp_req) begin
                        dp_gnt = 1'b1;
                    end else if (ctl_req && val_req) begin
                        // Tie: the requester not granted last time wins.
                        if (rr_last_q == RR_VAL) begin
                            ctl_gnt = 1'b1;
                        end else begin
                            val_gnt = 1'b1;
                        end
                    end else if (ctl_req) begin
                        ctl_gnt = 1'b1;
                    end else if (val_req) begin
                        val_gnt = 1'b1;
                    end

                    if (ctl_gnt) begin
                        rr_last_d = RR_CTL;
                    end else if (val_gnt) begin
                        rr_last_d = RR_VAL;
                    end

                    if (dp_gnt) begin
                        mem_addr = dp_addr;
                    end else if (ctl_gnt) begin
                        mem_addr = ctl_addr;
                    end else if (val_gnt) begin
                        mem_addr = val_addr;
                    end
                    mem_we    = dp_gnt & dp_we;
                    mem_wdata = dp_wdata;

                    ctl_rvalid_d = ctl_gnt;
                    val_rvalid_d = val_gnt;
                    dp_rvalid_d  = dp_gnt & ~dp_we;

                    // This cycle's access still completes; init begins next cycle.
                    if (init_req) begin
                        state_d = INIT;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    // State, init counter, round-robin pointer and read-valid flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            rr_last_q    <= RR_VAL;
            ctl_rvalid_q <= 1'b0;
            val_rvalid_q <= 1'b0;
            dp_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_last_q    <= rr_last_d;
            ctl_rvalid_q <= ctl_rvalid_d;
            val_rvalid_q <= val_rvalid_d;
            dp_rvalid_q  <= dp_rvalid_d;
        end
    end

    assign ctl_rvalid = ctl_rvalid_q;
    assign val_rvalid = val_rvalid_q;
    assign dp_rvalid  = dp_rvalid_q;
    assign rdata      = mem_q;
    assign state_dbg  = (state_q == INIT);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed testbench for board_mem_arbiter with a behavioural 64x4 RAM.
module tb_board_mem_arbiter;

    localparam int WHO_CTL = 0;
    localparam int WHO_VAL = 1;
    localparam int WHO_DP  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_req = 1'b0;
    logic       init_busy;
    logic       ctl_req = 1'b0;
    logic [5:0] ctl_addr = '0;
    logic       ctl_gnt, ctl_rvalid;
    logic       val_req = 1'b0;
    logic [5:0] val_addr = '0;
    logic       val_gnt, val_rvalid;
    logic       dp_req = 1'b0;
    logic       dp_we = 1'b0;
    logic [5:0] dp_addr = '0;
    logic [3:0] dp_wdata = '0;
    logic       dp_gnt, dp_rvalid;
    logic [3:0] rdata;
    logic [5:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       mem_we;
    logic [3:0] mem_q;
    logic       state_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    board_mem_arbiter #(.ADDR_W(6), .DATA_W(4), .INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .init_req(init_req), .init_busy(init_busy),
        .ctl_req(ctl_req), .ctl_addr(ctl_addr), .ctl_gnt(ctl_gnt), .ctl_rvalid(ctl_rvalid),
        .val_req(val_req), .val_addr(val_addr), .val_gnt(val_gnt), .val_rvalid(val_rvalid),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .state_dbg(state_dbg)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Behavioural single-port RAM, registered read
    logic [3:0] ram [64];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // Starting position, written out row by row
    function automatic logic [3:0] start_val(input int a);
        int y, x;
        logic [3:0] row0 [8];
        logic [3:0] row7 [8];
        row0 = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        row7 = '{4'd10, 4'd8, 4'd9, 4'd11, 4'd12, 4'd9, 4'd8, 4'd10};
        y = a / 8;
        x = a % 8;
        if (y == 0) return row0[x];
        if (y == 1) return 4'd1;
        if (y == 6) return 4'd7;
        if (y == 7) return row7[x];
        return 4'd0;
    endfunction

    function automatic logic gnt_of(input int who);
        if (who == WHO_CTL) return ctl_gnt;
        if (who == WHO_VAL) return val_gnt;
        return dp_gnt;
    endfunction

    function automatic logic rvalid_of(input int who);
        if (who == WHO_CTL) return ctl_rvalid;
        if (who == WHO_VAL) return val_rvalid;
        return dp_rvalid;
    endfunction

    task automatic set_req(input int who, input logic [5:0] a, input logic on);
        if (who == WHO_CTL) begin ctl_req = on; ctl_addr = a; end
        else if (who == WHO_VAL) begin val_req = on; val_addr = a; end
        else begin dp_req = on; dp_addr = a; dp_we = 1'b0; end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single read: hold request until granted, then check rvalid/rdata
    task automatic do_read(input int who, input logic [5:0] a, input logic [3:0] exp, input string tag);
        int k;
        set_req(who, a, 1'b1);
        #1;
        k = 0;
        while (!gnt_of(who) && k < 200) begin
            step();
            #1;
            k++;
        end
        check({tag, "_gnt"}, gnt_of(who), 1'b1);
        step();
        set_req(who, a, 1'b0);
        check({tag, "_rvalid"}, rvalid_of(who), 1'b1);
        check({tag, "_rdata"}, rdata, exp);
    endtask

    task automatic dp_write(input logic [5:0] a, input logic [3:0] d);
        dp_req = 1'b1; dp_we = 1'b1; dp_addr = a; dp_wdata = d;
        #1;
        check("dp_wr_gnt", dp_gnt, 1'b1);
        check("dp_wr_we", mem_we, 1'b1);
        step();
        dp_req = 1'b0; dp_we = 1'b0;
    endtask

    // Count cycles with init_busy high; also count any grant seen meanwhile
    task automatic count_busy(output int busy_n, output int gnt_n);
        busy_n = 0;
        gnt_n  = 0;
        #1;
        while (init_busy && busy_n < 200) begin
            if (ctl_gnt || val_gnt || dp_gnt) gnt_n++;
            busy_n++;
            step();
            #1;
        end
    endtask

    initial begin
        int busy_n, gnt_n, bad;

        // ---- 1: reset and automatic init ----
        ctl_req = 1'b1; val_req = 1'b1; dp_req = 1'b1;
        repeat (3) step();
        #1;
        check("rst_busy", init_busy, 1'b1);
        check("rst_we", mem_we, 1'b0);
        check("rst_gnt", {ctl_gnt, val_gnt, dp_gnt}, 3'b000);
        check("rst_rvalid", {ctl_rvalid, val_rvalid, dp_rvalid}, 3'b000);
        ctl_req = 1'b0; val_req = 1'b0; dp_req = 1'b0;
        reset = 1'b0;
        #1;
        check("init_first_addr", mem_addr, 6'd0);
        check("init_first_data", mem_wdata, 4'd4);
        count_busy(busy_n, gnt_n);
        check("init_len", busy_n, 64);
        check("init_busy_low", init_busy, 1'b0);
        do_read(WHO_CTL, 6'd4, 4'd6, "rd4");
        do_read(WHO_DP, 6'd60, 4'd12, "rd60");
        do_read(WHO_CTL, 6'd9, 4'd1, "rd9");
        do_read(WHO_CTL, 6'd27, 4'd0, "rd27");
        do_read(WHO_VAL, 6'd48, 4'd7, "rd48");

        // ---- 2: three-way contention, rr_last = VAL ----
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 6'd4;
        ctl_req = 1'b1; ctl_addr = 6'd60;
        val_req = 1'b1; val_addr = 6'd9;
        #1;
        check("t2_c0_gnt", {ctl_gnt, val_gnt, dp_gnt}, 3'b001);
        step();
        dp_req = 1'b0;
        #1;
        check("t2_c1_gnt", {ctl_gnt, val_gnt, dp_gnt}, 3'b100);
        check("t2_c1_rv", {ctl_rvalid, val_rvalid, dp_rvalid}, 3'b001);
        check("t2_c1_rdata", rdata, 4'd6);
        step();
        ctl_req = 1'b0;
        #1;
        check("t2_c2_gnt", {ctl_gnt, val_gnt, dp_gnt}, 3'b010);
        check("t2_c2_rv", {ctl_rvalid, val_rvalid, dp_rvalid}, 3'b100);
        check("t2_c2_rdata", rdata, 4'd12);
        step();
        val_req = 1'b0;
        #1;
        check("t2_c3_rv", {ctl_rvalid, val_rvalid, dp_rvalid}, 3'b010);
        check("t2_c3_rdata", rdata, 4'd1);

        // ---- 3: ctl and val held for 6 cycles -> alternate ----
        ctl_req = 1'b1; ctl_addr = 6'd0;
        val_req = 1'b1; val_addr = 6'd63;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t3_ctl_%0d", i), ctl_gnt, (i % 2) == 0);
            check($sformatf("t3_val_%0d", i), val_gnt, (i % 2) == 1);
            if (i > 0) check($sformatf("t3_rdata_%0d", i), rdata, ((i % 2) == 1) ? 4'd4 : 4'd10);
            step();
        end
        ctl_req = 1'b0; val_req = 1'b0;
        #1;
        check("t3_last_rv", {ctl_rvalid, val_rvalid}, 2'b01);

        // ---- 4: write then read-back ----
        dp_write(6'd35, 4'd11);
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 6'd35;
        #1;
        check("t4_rd_gnt", dp_gnt, 1'b1);
        check("t4_wr_no_rv", dp_rvalid, 1'b0);
        step();
        dp_req = 1'b0;
        check("t4_rd_rv", dp_rvalid, 1'b1);
        check("t4_rd_data", rdata, 4'd11);
        do_read(WHO_CTL, 6'd35, 4'd11, "t4_ctl35");

        // ---- 5: init_req alongside a val grant ----
        val_req = 1'b1; val_addr = 6'd27; init_req = 1'b1;
        #1;
        check("t5_val_gnt", val_gnt, 1'b1);
        step();
        init_req = 1'b0; val_req = 1'b0;
        ctl_req = 1'b1; ctl_addr = 6'd0;
        check("t5_val_rv", val_rvalid, 1'b1);
        check("t5_val_rdata", rdata, 4'd0);
        count_busy(busy_n, gnt_n);
        check("t5_init_len", busy_n, 64);
        check("t5_no_gnt", gnt_n, 0);
        check("t5_held_gnt", ctl_gnt, 1'b1);
        step();
        ctl_req = 1'b0;
        check("t5_held_rv", ctl_rvalid, 1'b1);
        check("t5_held_rdata", rdata, 4'd4);
        do_read(WHO_VAL, 6'd35, 4'd0, "t5_reload35");

        // ---- 6: reset at INIT cnt = 30 ----
        dp_write(6'd5, 4'd0);
        dp_write(6'd50, 4'd3);
        dp_write(6'd12, 4'd9);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        repeat (30) step();
        check("t6_cnt30", mem_addr, 6'd30);
        reset = 1'b1;
        #1;
        check("t6_rst_we", mem_we, 1'b0);
        check("t6_rst_busy", init_busy, 1'b1);
        step();
        reset = 1'b0;
        #1;
        check("t6_restart_addr", mem_addr, 6'd0);
        count_busy(busy_n, gnt_n);
        check("t6_init_len", busy_n, 64);
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            do_read(a % 3, 6'(a), start_val(a), $sformatf("t6_sq%0d", a));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
Owns the single-port 64x4 board RAM, which holds one piece code per square. It shares the RAM between three requesters: the control FSM (cursor reads), the move validator (square reads) and the datapath (move reads and writes). It also runs a sequencer that writes the standard starting position into the RAM after reset or on command. It sits between the memory_access wrapper and the control, validator and datapath modules.

Parameters:
ADDR_W, 6, square address width; addr = y*8 + x, so y = addr[5:3] and x = addr[2:0].
DATA_W, 4, piece code width, using the team piece lookup table (0 empty, 1-6 black P N B R Q K, 7-12 white P N B R Q K).
INIT_ON_RESET, 1, 1 = run the init sequence automatically after reset; 0 = stay IDLE until init_req.

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high
init_req  in  1  one-cycle pulse: reload the starting position
init_busy  out  1  high while the init sequence owns the RAM
ctl_req  in  1  control read request; held until granted
ctl_addr  in  6  control read address
ctl_gnt  out  1  control access taken this cycle
ctl_rvalid  out  1  rdata holds the control result
val_req  in  1  validator read request
val_addr  in  6  validator read address
val_gnt  out  1  validator access taken this cycle
val_rvalid  out  1  rdata holds the validator result
dp_req  in  1  datapath request
dp_we  in  1  1 = write, 0 = read
dp_addr  in  6  datapath address
dp_wdata  in  4  datapath write data
dp_gnt  out  1  datapath access taken this cycle
dp_rvalid  out  1  rdata holds the datapath read result
rdata  out  4  shared read data, equal to mem_q
mem_addr  out  6  RAM address
mem_wdata  out  4  RAM write data
mem_we  out  1  RAM write enable
mem_q  in  4  RAM read data, valid 1 cycle after mem_addr

Behaviour:
- FSM states: IDLE, INIT.
- Reset: next state is INIT if INIT_ON_RESET, else IDLE. cnt <= 0. rr_last <= VAL, so CTL wins the first tie. All *_rvalid <= 0.
- While reset is high: all gnt = 0, mem_we = 0, init_busy = 1.
- INIT:
  - Each cycle: mem_we = 1, mem_addr = cnt, mem_wdata = start_table(cnt), cnt <= cnt + 1.
  - After the write at cnt = 63, go to IDLE; cnt wraps to 0.
  - The sequence is exactly 64 cycles. init_busy = 1 and all gnt = 0 throughout.
  - init_req is ignored while in INIT.
- start_table(y, x):
  - y = 0: 4 2 3 5 6 3 2 4 for x = 0..7.
  - y = 1: 1.
  - y = 2..5: 0.
  - y = 6: 7.
  - y = 7: 10 8 9 11 12 9 8 10 for x = 0..7.
- IDLE: combinational grant, at most one gnt per cycle.
  - dp_req wins.
  - Otherwise, if only one of ctl_req / val_req is high, grant it.
  - If both are high, grant the one that is not rr_last.
  - rr_last updates only on a ctl or val grant.
- Granted cycle: mem_addr = granted addr; mem_we = dp_gnt & dp_we; mem_wdata = dp_wdata. Idle cycles: mem_addr = 0, mem_we = 0.
- Read latency is 1 cycle:
  - x_rvalid <= x_gnt & read, registered.
  - rdata = mem_q, meaningful only when some rvalid is high.
  - At most one rvalid is high per cycle. Writes never produce rvalid.
- A requester must hold req/addr/we/wdata stable until gnt. The grant cycle consumes the request; asserting req again on the next cycle is a new access.
- init_req in IDLE: the current cycle is still arbitrated normally and its rvalid still fires next cycle. INIT starts next cycle.
- Reset mid-INIT: restart from cnt = 0 (or go to IDLE if INIT_ON_RESET = 0). Reset clears any pending rvalid.
- A read of an address written in the previous cycle returns the new value. Write-then-read ordering is guaranteed by grant order.

Test Plan:
1. Reset, INIT_ON_RESET = 1 -> init_busy high for 64 cycles after release, then low. Reading addr 4 (y0, x4) gives 6; addr 60 gives 12; addr 9 gives 1; addr 27 gives 0; addr 48 gives 7.
2. dp_req, ctl_req, val_req all high in the same IDLE cycle -> dp_gnt only. Next cycle ctl_gnt (rr_last = VAL), following cycle val_gnt; each rvalid lags its gnt by exactly 1 cycle.
3. ctl_req and val_req held high continuously for 6 cycles -> grants alternate ctl, val, ctl, val, ctl, val; never two in a row to the same requester.
4. dp write addr 35 data 11, then dp read addr 35 on the next cycle -> dp_rvalid with rdata = 11. Then ctl read addr 35 -> rdata = 11.
5. init_req pulsed in the same cycle as a val grant -> val_rvalid fires next cycle. Then 64 INIT cycles with every gnt low despite held requests; the held request is granted on the first IDLE cycle.
6. Reset asserted at INIT cnt = 30 for 1 cycle -> init restarts at 0, runs a full 64 cycles, and the board matches start_table.
